transfer_layer_nch: RTL
=======================

TRANSFER_LAYER_NCH -- requirements
Module: transfer_layer_nch

Interface
REQ-001 Parameters SHALL be: DATA_W=12 (word width); NCH=4 (output channels, power of 2, 2..8); DEPTH=8 (entries per FIFO, power of 2); CNT_W=5 (pop-counter width); CW=log2(NCH); AW=log2(DEPTH).
REQ-002 Ports SHALL be: clk in 1, the single clock. reset in 1, asynchronous active-low reset.
REQ-003 Ports SHALL be: init in 1, latches the thresholds. umbral_bajo in AW, low threshold. umbral_alto in AW, high threshold.
REQ-004 Ports SHALL be: push_in in 1, write strobe. data_in in DATA_W, word whose top CW bits select the channel. full_in out 1, input FIFO full.
REQ-005 Ports SHALL be: pop_out in NCH, per-channel read strobes. data_out out NCH*DATA_W, per-channel registered words. valid_out out NCH. empty_out out NCH.
REQ-006 Ports SHALL be: pause out 1, hysteretic backpressure. error out 1, sticky overflow flag. state out 3, FSM state.
REQ-007 Ports SHALL be: req in 1, counter read request. idx in CW, channel to read. counter_out out CNT_W. counter_valid out 1.

Function
REQ-008 Channel SHALL be data_in[DATA_W-1 -: CW]; the full word SHALL be stored unchanged.
REQ-009 FSM states SHALL be RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-010 FSM transitions SHALL be: RESET->INIT unconditionally; INIT->IDLE on the first cycle with init=0; IDLE->ACTIVE when any FIFO is non-empty; ACTIVE->IDLE when all FIFOs are empty; any state->ERROR on overflow; ERROR->INIT on init=1.
REQ-011 Thresholds SHALL be latched while state==INIT or init=1, and SHALL be held otherwise.
REQ-012 Push while full_in=1 SHALL be an overflow: the word is dropped, error is set, and FIFO contents are kept.
REQ-013 Transfer SHALL move at most one word per cycle from the input FIFO head to its channel FIFO.
REQ-014 Transfer SHALL occur only when: input FIFO not empty, pause=0, destination not full, and state is IDLE or ACTIVE.
REQ-015 A blocked head SHALL stall the input FIFO: no reordering and no bypass.
REQ-016 Latency SHALL be: push at edge t, earliest channel-FIFO occupancy at t+1, earliest data_out at the edge after pop_out.
REQ-017 A pop on an empty channel SHALL be ignored: valid_out stays 0 and data_out holds its value.
REQ-018 pause SHALL go to 1 when any channel occupancy >= umbral_alto; it SHALL go to 0 only when every channel occupancy <= umbral_bajo.
REQ-019 When umbral_alto=0, pause SHALL stay 0 (thresholds disabled).
REQ-020 Per-channel counters SHALL increment on each accepted pop and saturate at 2^CNT_W-1.
REQ-021 A req at edge t SHALL give counter_out=count[idx] and counter_valid=1 at t+1; counter_valid SHALL be 0 otherwise.
REQ-022 If req and a pop on the same channel occur in the same cycle, counter_out SHALL report the pre-increment value.
REQ-023 Simultaneous push and transfer on a full input FIFO SHALL be accepted with no overflow.

Reset
REQ-024 On reset=0 all FIFOs SHALL empty, counters clear, and thresholds go to 0.
REQ-025 On reset=0: data_out=0, valid_out=0, empty_out=all 1s, full_in=0, pause=0, error=0, counter_out=0, counter_valid=0, state=RESET.
REQ-026 Reset assertion mid-transfer SHALL discard in-flight words; no partial writes.

Structure
REQ-027 The shared package SHALL hold the FSM state encoding and default parameter constants.
REQ-028 The block SHALL use one sub-module, fifo_sync (parametrised DATA_W, DEPTH, exposing occupancy), instantiated NCH+1 times.

Verification
REQ-029 Reset, then init with umbral_alto=6: state SHALL pass 0->1->2; empty_out=4'b1111.
REQ-030 Push 'b010111111111, 'b101011111111, 'b111111111111: channels 1, 2, 3 SHALL each pop the exact word with valid_out=1 one cycle after the pop.
REQ-031 With umbral_alto=6 and umbral_bajo=2, push 6 words to channel 0: pause SHALL rise; after 4 pops pause SHALL fall.
REQ-032 Fill the input FIFO while paused and push a 9th word: error=1 and state=4; init=1 SHALL return state to 1.
REQ-033 Pop channel 2 thirty-five times: req with idx=2 SHALL return counter_out=31 (saturated) and counter_valid=1 on the next cycle.
REQ-034 Assert reset mid-stream: all outputs SHALL reach their reset values asynchronously and no word SHALL appear after release.

Source files
------------

// File: rtl/transfer_layer_nch_pkg.sv
// Shared definitions for the multi-channel transfer layer: FSM state encoding
// and default parameter values.
package transfer_layer_nch_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int NCH_DEF    = 4;
   localparam int DEPTH_DEF  = 8;
   localparam int CNT_W_DEF  = 5;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_e;

endpackage

// File: rtl/transfer_layer_nch_fifo_sync.sv
// Show-ahead synchronous FIFO with occupancy output; a push on a full FIFO is
// accepted when a pop happens in the same cycle.
module fifo_sync
   import transfer_layer_nch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [DATA_W-1:0]      wdata_i,
   input  logic                   pop_i,
   output logic [DATA_W-1:0]      rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              do_push;
   logic              do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // NOTE: storage is deliberately not reset; count_q qualifies every read, so stale entries are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/transfer_layer_nch.sv
// Routes words from one input FIFO to NCH channel FIFOs by their top bits, with
// hysteretic backpressure, sticky overflow detection and per-channel pop counters.
module transfer_layer_nch
   import transfer_layer_nch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NCH    = NCH_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int CW     = $clog2(NCH),
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic [AW-1:0]         umbral_bajo,
   input  logic [AW-1:0]         umbral_alto,
   input  logic                  push_in,
   input  logic [DATA_W-1:0]     data_in,
   output logic                  full_in,
   input  logic [NCH-1:0]        pop_out,
   output logic [NCH*DATA_W-1:0] data_out,
   output logic [NCH-1:0]        valid_out,
   output logic [NCH-1:0]        empty_out,
   output logic                  pause,
   output logic                  error,
   output logic [2:0]            state,
   input  logic                  req,
   input  logic [CW-1:0]         idx,
   output logic [CNT_W-1:0]      counter_out,
   output logic                  counter_valid
);

   state_e            state_q, state_d;
   logic [AW-1:0]     alto_q, bajo_q;
   logic              pause_q, pause_d;
   logic              error_q;
   logic [DATA_W-1:0] dout_q [NCH];
   logic [NCH-1:0]    valid_q;
   logic [CNT_W-1:0]  cnt_q [NCH];
   logic [CNT_W-1:0]  cout_q;
   logic              cvalid_q;

   logic [DATA_W-1:0] in_head;
   logic              in_full, in_empty;
   logic [AW:0]       in_count;
   logic [CW-1:0]     ch_sel;
   logic [NCH-1:0]    ch_push, ch_full, ch_empty;
   logic [DATA_W-1:0] ch_head [NCH];
   logic [AW:0]       ch_count [NCH];
   logic              xfer, overflow, any_data, any_hi, all_lo;

   fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push_in),
      .wdata_i (data_in),
      .pop_i   (xfer),
      .rdata_o (in_head),
      .full_o  (in_full),
      .empty_o (in_empty),
      .count_o (in_count)
   );

   assign ch_sel   = in_head[DATA_W-1 -: CW];
   assign xfer     = !in_empty && !pause_q && !ch_full[ch_sel] &&
                     (state_q == ST_IDLE || state_q == ST_ACTIVE);
   // A push on a full input FIFO survives only if the head leaves in the same cycle.
   assign overflow = push_in && in_full && !xfer;
   assign any_data = (in_count != '0) || (ch_empty != '1);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign ch_push[c] = xfer && (ch_sel == CW'(c));

      fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ch_fifo (
         .clk     (clk),
         .rst_n   (reset),
         .push_i  (ch_push[c]),
         .wdata_i (in_head),
         .pop_i   (pop_out[c]),
         .rdata_o (ch_head[c]),
         .full_o  (ch_full[c]),
         .empty_o (ch_empty[c]),
         .count_o (ch_count[c])
      );

      assign data_out[c*DATA_W +: DATA_W] = dout_q[c];
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      any_hi  = 1'b0;
      all_lo  = 1'b1;
      pause_d = pause_q;
      for (int c = 0; c < NCH; c++) begin
         if (ch_count[c] >= {1'b0, alto_q}) any_hi = 1'b1;
         if (ch_count[c] >  {1'b0, bajo_q}) all_lo = 1'b0;
      end
      if (alto_q == '0)  pause_d = 1'b0;
      else if (any_hi)   pause_d = 1'b1;
      else if (all_lo)   pause_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   if (!init)     state_d = ST_IDLE;
         ST_IDLE:   if (any_data)  state_d = ST_ACTIVE;
         ST_ACTIVE: if (!any_data) state_d = ST_IDLE;
         ST_ERROR:  if (init)      state_d = ST_INIT;
         default:   state_d = ST_RESET;
      endcase
      if (overflow) state_d = ST_ERROR;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RESET;
         alto_q   <= '0;
         bajo_q   <= '0;
         pause_q  <= 1'b0;
         error_q  <= 1'b0;
         valid_q  <= '0;
         cout_q   <= '0;
         cvalid_q <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            dout_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
      end else begin
         state_q  <= state_d;
         pause_q  <= pause_d;
         if (overflow) error_q <= 1'b1;
         if (state_q == ST_INIT || init) begin
            alto_q <= umbral_alto;
            bajo_q <= umbral_bajo;
         end
         // Counter snapshot reads the pre-increment value when a pop hits the same channel.
         cvalid_q <= req;
         if (req) cout_q <= cnt_q[idx];
         for (int c = 0; c < NCH; c++) begin
            if (pop_out[c] && !ch_empty[c]) begin
               dout_q[c]  <= ch_head[c];
               valid_q[c] <= 1'b1;
               if (cnt_q[c] != '1) cnt_q[c] <= cnt_q[c] + 1'b1;
            end else begin
               valid_q[c] <= 1'b0;
            end
         end
      end
   end

   assign full_in       = in_full;
   assign empty_out     = ch_empty;
   assign valid_out     = valid_q;
   assign pause         = pause_q;
   assign error         = error_q;
   assign state         = state_q;
   assign counter_out   = cout_q;
   assign counter_valid = cvalid_q;

endmodule
